decode_ctrl: RTL and testbench

//  Decode-stage controller between fetch and execute. Captures each fetched instruction into
//  the ID pipeline register using a valid/ready handshake. Decodes the opcode into imm_sel for
//  the immediate generator and into control flags. Inserts load-use bubbles and applies branch
//  and jump flushes.

---
 rtl/decode_ctrl.sv | 170 +++++++++++++++++
 tb/tb_decode_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl.sv
// Decode-stage controller: captures fetched instructions into the ID register, decodes the
// opcode into immediate type and class flags, inserts load-use bubbles and applies flushes.
module decode_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [1:0]  imm_sel,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        illegal
);

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [2:0]  STALL_INIT = 3'(STALL_CYCLES);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {StEmpty, StFull, StStall} state_e;

    state_e     state;
    logic [2:0] stall_cnt;

    logic [1:0] dec_imm_sel;
    logic       dec_we, dec_load, dec_store, dec_branch, dec_jal, dec_jalr, dec_illegal;
    logic       dec_use_rs1, dec_use_rs2;
    logic       hazard, transfer, capture;

    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];
    assign rd  = id_instr[11:7];

    // Decode the incoming fetch word; results are registered at capture.
    always_comb begin
        dec_imm_sel = 2'd0;
        dec_we      = 1'b1;
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_branch  = 1'b0;
        dec_jal     = 1'b0;
        dec_jalr    = 1'b0;
        dec_illegal = 1'b0;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b0;
        case (if_instr[6:0])
            OP_LOAD:   dec_load = 1'b1;
            OP_IMM:    ;
            OP_JALR:   dec_jalr = 1'b1;
            OP_STORE: begin
                dec_imm_sel = 2'd1;
                dec_store   = 1'b1;
                dec_we      = 1'b0;
                dec_use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm_sel = 2'd2;
                dec_branch  = 1'b1;
                dec_we      = 1'b0;
                dec_use_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm_sel = 2'd3;
                dec_use_rs1 = 1'b0;
            end
            // J immediate is assembled in EX, so the I slot is reported here.
            OP_JAL: begin
                dec_jal     = 1'b1;
                dec_use_rs1 = 1'b0;
            end
            OP_REG:    dec_use_rs2 = 1'b1;
            OP_SYSTEM: begin
                dec_we      = 1'b0;
                dec_use_rs1 = 1'b0;
            end
            default: begin
                dec_illegal = 1'b1;
                dec_we      = 1'b0;
                dec_use_rs1 = 1'b0;
            end
        endcase
    end

    // Load-use detection against the held load, plus the fetch handshake.
    always_comb begin
        hazard = id_valid && is_load && (rd != 5'd0) && if_valid &&
                 ((dec_use_rs1 && (if_instr[19:15] == rd)) ||
                  (dec_use_rs2 && (if_instr[24:20] == rd)));
        transfer = id_valid && ex_ready;
        id_ready = !flush && (state != StStall) && (!id_valid || ex_ready) && !hazard;
        capture  = if_valid && id_ready;
    end

    // State, stall counter and the registered ID contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StEmpty;
            stall_cnt <= 3'd0;
            id_valid  <= 1'b0;
            id_instr  <= NOP;
            id_pc     <= RESET_PC;
            imm_sel   <= 2'd0;
            reg_we    <= 1'b0;
            is_load   <= 1'b0;
            is_store  <= 1'b0;
            is_branch <= 1'b0;
            is_jal    <= 1'b0;
            is_jalr   <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            // Any transfer this cycle still completes; EX is responsible for the kill.
            state     <= StEmpty;
            stall_cnt <= 3'd0;
            id_valid  <= 1'b0;
        end else if (state == StStall) begin
            if (stall_cnt <= 3'd1) begin
                state     <= StEmpty;
                stall_cnt <= 3'd0;
            end else begin
                stall_cnt <= stall_cnt - 3'd1;
            end
        end else if (capture) begin
            state     <= StFull;
            id_valid  <= 1'b1;
            id_instr  <= if_instr;
            id_pc     <= if_pc;
            imm_sel   <= dec_imm_sel;
            reg_we    <= dec_we && (if_instr[11:7] != 5'd0);
            is_load   <= dec_load;
            is_store  <= dec_store;
            is_branch <= dec_branch;
            is_jal    <= dec_jal;
            is_jalr   <= dec_jalr;
            illegal   <= dec_illegal;
        end else if (hazard && transfer) begin
            state     <= StStall;
            stall_cnt <= STALL_INIT;
            id_valid  <= 1'b0;
        end else if (transfer) begin
            state    <= StEmpty;
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: two instances (1 and 3 stall cycles) share one stimulus stream and
// are each compared against a cycle-level reference model of the ID stage.
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        ex_ready;
    logic        flush;

    logic        id_ready_w[2];
    logic        id_valid_w[2];
    logic [31:0] id_instr_w[2];
    logic [31:0] id_pc_w[2];
    logic [1:0]  imm_sel_w[2];
    logic [4:0]  rs1_w[2], rs2_w[2], rd_w[2];
    logic        reg_we_w[2], ld_w[2], st_w[2], br_w[2], jal_w[2], jalr_w[2], ill_w[2];

    int unsigned stall_p[2]  = '{1, 3};
    logic [31:0] reset_pc[2] = '{32'h0000_0000, 32'h8000_0000};

    int checks = 0;
    int errors = 0;

    // Reference model state per instance.
    logic        m_valid[2];
    logic [31:0] m_instr[2];
    logic [31:0] m_pc[2];
    int          m_stall[2];
    int          bubbles[2];
    logic        count_en = 1'b0;

    always #5 clk = ~clk;

    decode_ctrl #(.RESET_PC(32'h0000_0000), .STALL_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready_w[0]), .ex_ready(ex_ready), .flush(flush),
        .id_valid(id_valid_w[0]), .id_instr(id_instr_w[0]), .id_pc(id_pc_w[0]),
        .imm_sel(imm_sel_w[0]), .rs1(rs1_w[0]), .rs2(rs2_w[0]), .rd(rd_w[0]),
        .reg_we(reg_we_w[0]), .is_load(ld_w[0]), .is_store(st_w[0]), .is_branch(br_w[0]),
        .is_jal(jal_w[0]), .is_jalr(jalr_w[0]), .illegal(ill_w[0])
    );

    decode_ctrl #(.RESET_PC(32'h8000_0000), .STALL_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready_w[1]), .ex_ready(ex_ready), .flush(flush),
        .id_valid(id_valid_w[1]), .id_instr(id_instr_w[1]), .id_pc(id_pc_w[1]),
        .imm_sel(imm_sel_w[1]), .rs1(rs1_w[1]), .rs2(rs2_w[1]), .rd(rd_w[1]),
        .reg_we(reg_we_w[1]), .is_load(ld_w[1]), .is_store(st_w[1]), .is_branch(br_w[1]),
        .is_jal(jal_w[1]), .is_jalr(jalr_w[1]), .illegal(ill_w[1])
    );

    // Expected decode of one instruction: immediate type, writes-rd class, flags
    // {load,store,branch,jal,jalr,illegal}, and which source registers it reads.
    typedef struct packed {
        logic [1:0] imm;
        logic       we;
        logic [5:0] flags;
        logic       u1;
        logic       u2;
    } dec_t;

    function automatic dec_t ref_dec(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000011: return '{2'd0, 1'b1, 6'b100000, 1'b1, 1'b0};
            7'b0010011: return '{2'd0, 1'b1, 6'b000000, 1'b1, 1'b0};
            7'b1100111: return '{2'd0, 1'b1, 6'b000010, 1'b1, 1'b0};
            7'b0100011: return '{2'd1, 1'b0, 6'b010000, 1'b1, 1'b1};
            7'b1100011: return '{2'd2, 1'b0, 6'b001000, 1'b1, 1'b1};
            7'b0110111: return '{2'd3, 1'b1, 6'b000000, 1'b0, 1'b0};
            7'b0010111: return '{2'd3, 1'b1, 6'b000000, 1'b0, 1'b0};
            7'b1101111: return '{2'd0, 1'b1, 6'b000100, 1'b0, 1'b0};
            7'b0110011: return '{2'd0, 1'b1, 6'b000000, 1'b1, 1'b1};
            7'b1110011: return '{2'd0, 1'b0, 6'b000000, 1'b0, 1'b0};
            default:    return '{2'd0, 1'b0, 6'b000001, 1'b0, 1'b0};
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [5:0] dut_flags(input int k);
        return {ld_w[k], st_w[k], br_w[k], jal_w[k], jalr_w[k], ill_w[k]};
    endfunction

    // Registered outputs against the model's ID contents.
    task automatic check_state(input int k);
        dec_t d;
        chk("id_valid", k, 32'(id_valid_w[k]), 32'(m_valid[k]));
        if (m_valid[k]) begin
            d = ref_dec(m_instr[k]);
            chk("id_instr", k, id_instr_w[k], m_instr[k]);
            chk("id_pc", k, id_pc_w[k], m_pc[k]);
            chk("imm_sel", k, 32'(imm_sel_w[k]), 32'(d.imm));
            chk("rs1", k, 32'(rs1_w[k]), 32'(m_instr[k][19:15]));
            chk("rs2", k, 32'(rs2_w[k]), 32'(m_instr[k][24:20]));
            chk("rd", k, 32'(rd_w[k]), 32'(m_instr[k][11:7]));
            chk("reg_we", k, 32'(reg_we_w[k]), 32'(d.we && (m_instr[k][11:7] != 5'd0)));
            chk("flags", k, 32'(dut_flags(k)), 32'(d.flags));
        end
    endtask

    task automatic check_reset(input int k);
        chk("rst_valid", k, 32'(id_valid_w[k]), 32'd0);
        chk("rst_instr", k, id_instr_w[k], 32'h0000_0013);
        chk("rst_pc", k, id_pc_w[k], reset_pc[k]);
        chk("rst_imm", k, 32'(imm_sel_w[k]), 32'd0);
        chk("rst_flags", k, 32'({reg_we_w[k], dut_flags(k)}), 32'd0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_instr[k] = 32'h0000_0013;
            m_pc[k]    = reset_pc[k];
            m_stall[k] = 0;
        end
    endtask

    // One clock: check registered state, drive inputs, check id_ready, advance model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic er, input logic fl);
        dec_t nd;
        logic hz, rdy;
        logic [4:0] lrd;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_state(k);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        ex_ready = er;
        flush    = fl;
        #1;
        nd = ref_dec(ins);
        for (int k = 0; k < 2; k++) begin
            lrd = m_instr[k][11:7];
            hz  = m_valid[k] && (m_instr[k][6:0] == 7'b0000011) && (lrd != 5'd0) && v &&
                  ((nd.u1 && ins[19:15] == lrd) || (nd.u2 && ins[24:20] == lrd));
            rdy = !fl && (m_stall[k] == 0) && (!m_valid[k] || er) && !hz;
            chk("id_ready", k, 32'(id_ready_w[k]), 32'(rdy));
            if (count_en && !id_valid_w[k] && !id_ready_w[k]) bubbles[k]++;
            if (fl) begin
                m_valid[k] = 1'b0;
                m_stall[k] = 0;
            end else if (m_stall[k] > 0) begin
                m_stall[k]--;
            end else if (v && rdy) begin
                m_valid[k] = 1'b1;
                m_instr[k] = ins;
                m_pc[k]    = pc;
            end else if (hz && er) begin
                m_valid[k] = 1'b0;
                m_stall[k] = int'(stall_p[k]);
            end else if (m_valid[k] && er) begin
                m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] ins;
        logic [6:0]  op;
        case ($urandom_range(0, 12))
            0, 1, 2: op = 7'b0000011;
            3:       op = 7'b0010011;
            4:       op = 7'b1100111;
            5:       op = 7'b0100011;
            6:       op = 7'b1100011;
            7:       op = 7'b0110111;
            8:       op = 7'b0010111;
            9:       op = 7'b1101111;
            10:      op = 7'b0110011;
            11:      op = 7'b1110011;
            default: op = 7'($urandom);
        endcase
        ins        = $urandom;
        ins[6:0]   = op;
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] SW     = 32'h0020_A023;
    localparam logic [31:0] BEQ    = 32'h0020_8063;
    localparam logic [31:0] LUI3   = 32'h0000_11B7;
    localparam logic [31:0] LW5    = 32'h0000_A283;
    localparam logic [31:0] ADD_U5 = 32'h0022_8333;
    localparam logic [31:0] LW0    = 32'h0000_A003;
    localparam logic [31:0] ADD_U0 = 32'h0020_0333;
    localparam logic [31:0] LUI5   = 32'h0002_82B7;
    localparam logic [31:0] ILL    = 32'h0000_007F;

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
        ex_ready = 1'b0; flush = 1'b0;
        bubbles = '{0, 0};
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) check_reset(k);
        @(negedge clk);
        rst = 1'b0;

        // Stream addi/sw/beq/lui back to back.
        cycle(1'b1, ADDI, 32'h100, 1'b1, 1'b0);
        cycle(1'b1, SW,   32'h104, 1'b1, 1'b0);
        cycle(1'b1, BEQ,  32'h108, 1'b1, 1'b0);
        cycle(1'b1, LUI3, 32'h10C, 1'b1, 1'b0);
        idle(2);

        // Load-use: bubble count must equal the configured stall length.
        cycle(1'b1, LW5, 32'h200, 1'b1, 1'b0);
        count_en = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b1, ADD_U5, 32'h204, 1'b1, 1'b0);
        count_en = 1'b0;
        for (int k = 0; k < 2; k++) chk("bubbles", k, 32'(bubbles[k]), stall_p[k]);
        idle(2);

        // No hazard: load to x0, and lui whose rs1 field matches the load rd.
        cycle(1'b1, LW0,    32'h300, 1'b1, 1'b0);
        cycle(1'b1, ADD_U0, 32'h304, 1'b1, 1'b0);
        cycle(1'b1, LW5,    32'h308, 1'b1, 1'b0);
        cycle(1'b1, LUI5,   32'h30C, 1'b1, 1'b0);

        // EX back-pressure for 4 cycles with a full ID.
        for (int i = 0; i < 4; i++) cycle(1'b1, ADDI, 32'h310, 1'b0, 1'b0);
        cycle(1'b1, ADDI, 32'h310, 1'b1, 1'b0);
        idle(1);

        // Flush during STALL, then during FULL.
        cycle(1'b1, LW5,    32'h400, 1'b1, 1'b0);
        cycle(1'b1, ADD_U5, 32'h404, 1'b1, 1'b0);
        cycle(1'b1, ADD_U5, 32'h404, 1'b1, 1'b1);
        cycle(1'b1, ADD_U5, 32'h404, 1'b1, 1'b0);
        cycle(1'b1, SW,     32'h408, 1'b0, 1'b1);
        cycle(1'b1, SW,     32'h408, 1'b0, 1'b0);
        idle(1);

        // Illegal opcode.
        cycle(1'b1, ILL, 32'h500, 1'b1, 1'b0);
        idle(1);

        // Asynchronous reset while both instances are stalling.
        cycle(1'b1, LW5,    32'h600, 1'b1, 1'b0);
        cycle(1'b1, ADD_U5, 32'h604, 1'b1, 1'b0);
        if_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check_reset(k);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 8), rnd_instr(), $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
